// File: rtl/idexe_pipe_reg.sv
// ID/EXE pipeline register: valid/ready elastic stage with a two-entry skid buffer and flush.
// Optional performance counters (stall_cnt, bubble_cnt) are built when IDEXE_PERF_CNT_EN is defined.
module idexe_pipe_reg #(
  parameter int DATA_W  = 64,
  parameter int OPC_W   = 11,
  parameter int RA_W    = 5,
  parameter int ALUOP_W = 2,
  parameter int CNT_W   = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  input  logic [ALUOP_W-1:0] ALUOp,
  input  logic               Reg2Loc,
  input  logic               ALUSrc,
  input  logic               MemtoReg,
  input  logic               RegWrite,
  input  logic               MemRead,
  input  logic               MemWrite,
  input  logic               Branch,
  input  logic [DATA_W-1:0]  PC,
  input  logic [DATA_W-1:0]  RD1,
  input  logic [DATA_W-1:0]  RD2,
  input  logic [DATA_W-1:0]  SE1out,
  input  logic [OPC_W-1:0]   Opcode,
  input  logic [RA_W-1:0]    Ins4_0,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ALUOP_W-1:0] ALUOp_s3,
  output logic               Reg2Loc_s3,
  output logic               ALUSrc_s3,
  output logic               MemtoReg_s3,
  output logic               RegWrite_s3,
  output logic               MemRead_s3,
  output logic               MemWrite_s3,
  output logic               Branch_s3,
  output logic [DATA_W-1:0]  PC_s3,
  output logic [DATA_W-1:0]  RD1_s3,
  output logic [DATA_W-1:0]  RD2_s3,
  output logic [DATA_W-1:0]  SE1out_s3,
  output logic [OPC_W-1:0]   Opcode_s3,
  output logic [RA_W-1:0]    Ins4_0_s3
`ifdef IDEXE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
`endif
);

  localparam int BW = ALUOP_W + 7 + 4 * DATA_W + OPC_W + RA_W;

  // Handshake: a bundle moves on a cycle where valid and ready are both high at
  // the rising edge; valid never depends on ready, and in_ready is a flop so the
  // EXE ready never reaches ID combinationally.
  logic          accept;
  logic          drain;
  logic [BW-1:0] in_bundle;
  logic [BW-1:0] main_q, main_d;
  logic [BW-1:0] skid_q, skid_d;
  logic          main_valid_q, main_valid_d;
  logic          skid_valid_q, skid_valid_d;
  logic          in_ready_q, in_ready_d;
  logic          reg_write_raw, mem_read_raw, mem_write_raw, branch_raw;

  assign in_bundle = {ALUOp, Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch,
                      PC, RD1, RD2, SE1out, Opcode, Ins4_0};

  assign accept = in_valid && in_ready_q;
  assign drain  = main_valid_q && out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      // Flush wins over everything; the drain this cycle already happened at EXE.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (drain && skid_valid_q) begin
      main_d       = skid_q;
      main_valid_d = 1'b1;
      skid_valid_d = accept;
      if (accept) skid_d = in_bundle;
    end else if (accept) begin
      if (!main_valid_q || drain) begin
        main_d       = in_bundle;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = in_bundle;
        skid_valid_d = 1'b1;
      end
    end else if (drain) begin
      main_valid_d = 1'b0;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;

  assign {ALUOp_s3, Reg2Loc_s3, ALUSrc_s3, MemtoReg_s3,
          reg_write_raw, mem_read_raw, mem_write_raw, branch_raw,
          PC_s3, RD1_s3, RD2_s3, SE1out_s3, Opcode_s3, Ins4_0_s3} = main_q;

  // Side-effecting controls must read as zero on a bubble so EXE/MEM never act on stale data.
  assign RegWrite_s3 = reg_write_raw & main_valid_q;
  assign MemRead_s3  = mem_read_raw  & main_valid_q;
  assign MemWrite_s3 = mem_write_raw & main_valid_q;
  assign Branch_s3   = branch_raw    & main_valid_q;

`ifdef IDEXE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (main_valid_q && !out_ready) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (!main_valid_q && !flush) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
